// File: rtl/freq_meas.sv
`default_nettype none
// ============================================================================
//  Module      : freq_meas
//  Description : Period and duty-cycle measurement of a slow square wave
//                sampled in the CLK_in domain. A START request arms the
//                block; it measures the number of CLK_in cycles between
//                two consecutive rising edges of the synchronized input,
//                and the high time in that window. It then presents the
//                result through a VALID/READY handshake. Counters
//                saturate, and a missing edge is reported as TIMEOUT.
//  Options     : FREQ_MEAS_MATCH_EN - adds the MATCH output. MATCH flags
//                a non-timeout period within +/-TOL of EXP_PERIOD.
//  Revision    : 1.0 - initial release
// ============================================================================
module freq_meas #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int EXP_PERIOD  = 10,
   parameter int TOL         = 0
) (
   input  logic             CLK_in,
   input  logic             RST,
   input  logic             SIG_in,
   input  logic             START,
   output logic             BUSY,
   output logic [CNT_W-1:0] PERIOD,
   output logic [CNT_W-1:0] HIGH_T,
   output logic             TIMEOUT,
   output logic             VALID,
   input  logic             READY
`ifdef FREQ_MEAS_MATCH_EN
   ,
   output logic             MATCH
`endif
);

   // Fewer than two synchronizer flops is never safe, so clamp to two.
   localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_MEAS = 2'd2,
      ST_HOLD = 2'd3
   } state_t;

   state_t             state_q,    state_d;
   logic [SYNC_N-1:0]  sync_q,     sync_d;
   logic               synced_dly_q, synced_dly_d;
   logic [CNT_W-1:0]   cnt_q,      cnt_d;       // ARM wait / MEAS period count
   logic [CNT_W-1:0]   hcnt_q,     hcnt_d;      // MEAS high-time count
   logic [CNT_W-1:0]   per_res_q,  per_res_d;
   logic [CNT_W-1:0]   high_res_q, high_res_d;
   logic               tmo_q,      tmo_d;
   logic               load_res;                // result registers load this cycle

   logic               synced;
   logic               rise;
   logic [CNT_W-1:0]   cnt_inc;
   logic [CNT_W-1:0]   hcnt_inc;

   // Synchronizer shift and one extra stage for edge detection.
   always_comb begin
      sync_d       = {sync_q[SYNC_N-2:0], SIG_in};
      synced_dly_d = sync_q[SYNC_N-1];
   end

   // Rising-edge pulse and saturating increments of both counters.
   always_comb begin
      synced   = sync_q[SYNC_N-1];
      rise     = synced & ~synced_dly_q;
      cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      hcnt_inc = (synced && (hcnt_q != CNT_MAX)) ? hcnt_q + CNT_ONE : hcnt_q;
   end

   // Next-state and counter/result update logic of the measurement FSM.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hcnt_d     = hcnt_q;
      per_res_d  = per_res_q;
      high_res_d = high_res_q;
      tmo_d      = tmo_q;
      load_res   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d = ST_ARM;
               cnt_d   = '0;
               hcnt_d  = '0;
            end
         end

         ST_ARM: begin
            if (rise) begin
               // First edge opens the measurement window.
               state_d = ST_MEAS;
               cnt_d   = '0;
               hcnt_d  = '0;
            end else if (cnt_inc == CNT_MAX) begin
               state_d    = ST_HOLD;
               load_res   = 1'b1;
               per_res_d  = CNT_MAX;
               high_res_d = hcnt_q;
               tmo_d      = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         ST_MEAS: begin
            if (rise) begin
               // The closing edge's own cycle belongs to this window.
               state_d    = ST_HOLD;
               load_res   = 1'b1;
               per_res_d  = cnt_inc;
               high_res_d = hcnt_inc;
               tmo_d      = 1'b0;
            end else if (cnt_inc == CNT_MAX) begin
               state_d    = ST_HOLD;
               load_res   = 1'b1;
               per_res_d  = CNT_MAX;
               high_res_d = hcnt_inc;
               tmo_d      = 1'b1;
            end else begin
               cnt_d  = cnt_inc;
               hcnt_d = hcnt_inc;
            end
         end

         ST_HOLD: begin
            if (READY) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, synchronizer, counter and result registers.
   always_ff @(posedge CLK_in or posedge RST) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         sync_q       <= '0;
         synced_dly_q <= 1'b0;
         cnt_q        <= '0;
         hcnt_q       <= '0;
         per_res_q    <= '0;
         high_res_q   <= '0;
         tmo_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         synced_dly_q <= synced_dly_d;
         cnt_q        <= cnt_d;
         hcnt_q       <= hcnt_d;
         per_res_q    <= per_res_d;
         high_res_q   <= high_res_d;
         tmo_q        <= tmo_d;
      end
   end

`ifdef FREQ_MEAS_MATCH_EN
   localparam logic [CNT_W-1:0] EXP_VAL = CNT_W'(EXP_PERIOD);
   localparam logic [CNT_W:0]   TOL_VAL = (CNT_W+1)'(TOL);

   logic               match_q, match_d;
   logic signed [CNT_W:0] diff;
   logic [CNT_W:0]     diff_mag;

   // Tolerance check on the period about to be captured; one extra bit
   // keeps the signed difference from overflowing.
   always_comb begin
      diff     = $signed({1'b0, per_res_d}) - $signed({1'b0, EXP_VAL});
      diff_mag = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
      match_d  = match_q;
      if (load_res) begin
         match_d = ~tmo_d & (diff_mag <= TOL_VAL);
      end
   end

   // MATCH is captured together with PERIOD on entry to HOLD.
   always_ff @(posedge CLK_in or posedge RST) begin
      if (RST) begin
         match_q <= 1'b0;
      end else begin
         match_q <= match_d;
      end
   end

   assign MATCH = match_q;
`else
   // Without the comparator the expected-period parameters carry no meaning.
   if ((EXP_PERIOD < 0) || (TOL < 0)) begin : g_cfg_unused
   end
`endif

   assign BUSY    = (state_q != ST_IDLE);
   assign VALID   = (state_q == ST_HOLD);
   assign PERIOD  = per_res_q;
   assign HIGH_T  = high_res_q;
   assign TIMEOUT = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_meas.sv
`default_nettype none
// ============================================================================
//  Module      : tb_freq_meas
//  Description : Directed self-checking bench for freq_meas (CNT_W=8).
//                Instance a expects a period of 10, instance b expects 9.
//                Both instances are driven by the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_meas;

   localparam int CW = 8;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          sig   = 1'b0;
   logic          start = 1'b0;
   logic          ready = 1'b0;

   logic          busy_a, tmo_a, valid_a;
   logic [CW-1:0] per_a, hi_a;
   logic          busy_b, tmo_b, valid_b;
   logic [CW-1:0] per_b, hi_b;
`ifdef FREQ_MEAS_MATCH_EN
   logic          match_a, match_b;
`endif

   int n_checks = 0;
   int n_err    = 0;

   // Signal generator controls: 0 = low, 1 = high, 2 = divider.
   int gen_mode = 0;
   int gen_div  = 2;
   int gen_high = 1;
   int gen_ph   = 0;

   freq_meas #(.CNT_W(CW), .SYNC_STAGES(2), .EXP_PERIOD(10), .TOL(0)) dut_a (
      .CLK_in (clk),
      .RST    (rst),
      .SIG_in (sig),
      .START  (start),
      .BUSY   (busy_a),
      .PERIOD (per_a),
      .HIGH_T (hi_a),
      .TIMEOUT(tmo_a),
      .VALID  (valid_a),
      .READY  (ready)
`ifdef FREQ_MEAS_MATCH_EN
      ,
      .MATCH  (match_a)
`endif
   );

   freq_meas #(.CNT_W(CW), .SYNC_STAGES(2), .EXP_PERIOD(9), .TOL(0)) dut_b (
      .CLK_in (clk),
      .RST    (rst),
      .SIG_in (sig),
      .START  (start),
      .BUSY   (busy_b),
      .PERIOD (per_b),
      .HIGH_T (hi_b),
      .TIMEOUT(tmo_b),
      .VALID  (valid_b),
      .READY  (ready)
`ifdef FREQ_MEAS_MATCH_EN
      ,
      .MATCH  (match_b)
`endif
   );

   always #5 clk = ~clk;

   // SIG_in generator, updated on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         case (gen_mode)
            0:       sig = 1'b0;
            1:       sig = 1'b1;
            default: begin
               sig    = (gen_ph < gen_high);
               gen_ph = (gen_ph + 1 >= gen_div) ? 0 : gen_ph + 1;
            end
         endcase
      end
   end

   // Watchdog.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_div(input int d, input int h);
      gen_ph   = 0;
      gen_div  = d;
      gen_high = h;
      gen_mode = 2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output int n);
      n = 0;
      while (valid_a !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_val("valid_wait", valid_a, 1);
   endtask

   task automatic handshake();
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      check_val("hs_valid", valid_a, 0);
      check_val("hs_busy", busy_a, 0);
   endtask

   task automatic check_res(input int per, input int hi, input int tmo, input int ma, input int mb);
      check_val("period", per_a, per);
      check_val("high_t", hi_a, hi);
      check_val("timeout", tmo_a, tmo);
      check_val("period_b", per_b, per);
      check_val("valid_b", valid_b, 1);
`ifdef FREQ_MEAS_MATCH_EN
      check_val("match_a", match_a, ma);
      check_val("match_b", match_b, mb);
`else
      if (ma < 0 || mb < 0) check_val("match_arg", ma, 0);
`endif
   endtask

   task automatic check_zero(input string tag);
      check_val({tag, "_busy"}, busy_a, 0);
      check_val({tag, "_valid"}, valid_a, 0);
      check_val({tag, "_timeout"}, tmo_a, 0);
      check_val({tag, "_period"}, per_a, 0);
      check_val({tag, "_high"}, hi_a, 0);
`ifdef FREQ_MEAS_MATCH_EN
      check_val({tag, "_match"}, match_a, 0);
`endif
   endtask

   initial begin
      int n;

      // Reset state.
      rst = 1'b1;
      tick(3);
      check_zero("reset");
      rst = 1'b0;
      tick(2);

      // 50% rate: toggle every cycle.
      set_div(2, 1);
      tick(8);
      pulse_start();
      check_val("start_busy", busy_a, 1);
      check_val("start_valid", valid_a, 0);
      wait_valid(300, n);
      check_res(2, 1, 0, 0, 0);
      tick(5);
      check_val("t1_hold_valid", valid_a, 1);
      check_val("t1_hold_period", per_a, 2);
      handshake();
      check_val("t1_persist", per_a, 2);

      // Divide-by-10, 5 high / 5 low.
      set_div(10, 5);
      tick(8);
      pulse_start();
      wait_valid(300, n);
      check_res(10, 5, 0, 1, 0);
      handshake();

      // Divide-by-100 with a second START during MEAS, READY held off.
      gen_mode = 0;
      tick(8);
      pulse_start();
      tick(3);
      set_div(100, 50);
      tick(30);
      pulse_start();
      check_val("meas_busy", busy_a, 1);
      check_val("meas_valid", valid_a, 0);
      wait_valid(400, n);
      check_res(100, 50, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         check_val("stall_valid", valid_a, 1);
         check_val("stall_period", per_a, 100);
         check_val("stall_high", hi_a, 50);
         tick(1);
      end
      // Handshake with a coincident START.
      ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      start = 1'b0;
      check_val("hs_start_valid", valid_a, 0);
      check_val("hs_start_busy", busy_a, 0);
      tick(150);
      check_val("one_result_busy", busy_a, 0);
      check_val("one_result_valid", valid_a, 0);
      check_val("one_result_persist", per_a, 100);

      // Divide-by-9: only instance b matches.
      set_div(9, 4);
      tick(8);
      pulse_start();
      wait_valid(300, n);
      check_res(9, 4, 0, 0, 1);
      handshake();

      // Stuck low: timeout from ARM after 255 cycles.
      gen_mode = 0;
      tick(8);
      pulse_start();
      wait_valid(400, n);
      check_val("arm_to_cycles", n, 255);
      check_res(255, 0, 1, 0, 0);
      handshake();

      // Stuck high after one edge: timeout from MEAS with full high time.
      gen_mode = 0;
      tick(8);
      pulse_start();
      gen_mode = 1;
      wait_valid(400, n);
      check_res(255, 255, 1, 0, 0);
      handshake();

      // Reset in the middle of MEAS.
      gen_mode = 0;
      tick(8);
      pulse_start();
      tick(3);
      set_div(100, 50);
      tick(40);
      check_val("pre_rst_busy", busy_a, 1);
      rst = 1'b1;
      #1;
      check_zero("mid_rst");
      tick(2);
      rst = 1'b0;
      set_div(10, 5);
      tick(8);
      pulse_start();
      wait_valid(300, n);
      check_res(10, 5, 0, 1, 0);
      handshake();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
